// File: rtl/infrarojo_scan.sv
// Time-multiplexed IR line-sensor scanner: steps the analog mux, lets it settle,
// majority-filters SAMPLES reads per channel and publishes an atomic snapshot.

module infrarojo_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

module infrarojo_scan #(
  parameter int N_CH    = 4,
  parameter int SETTLE  = 100,
  parameter int SAMPLES = 4,
  parameter int SEL_W   = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             ising,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  sensors,
  output logic             valid,
  output logic             scan_done,
  output logic             busy
);
  localparam int CNT_MAX = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ONES_W  = $clog2(SAMPLES + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLES - 1);
  localparam logic [ONES_W-1:0] HALF        = ONES_W'(SAMPLES / 2);
  localparam logic [SEL_W-1:0]  LAST_CH     = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_STORE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ONES_W-1:0]   ones;
  logic [N_CH-1:0]     shadow;
  logic [N_CH-1:0]     shadow_nxt;
  logic                ising_s;
  logic                ch_bit;

  infrarojo_sync #(.STAGES(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ising),
    .q     (ising_s)
  );

  // Strict majority: a tie counts as dark.
  assign ch_bit = (ones > HALF);

  // Shadow with the current channel's decision merged in, so the last channel
  // can be published in the same edge it is decided.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign shadow_nxt[i] = (sel == SEL_W'(i)) ? ch_bit : shadow[i];
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sel       <= '0;
      cnt       <= '0;
      ones      <= '0;
      shadow    <= '0;
      sensors   <= '0;
      valid     <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        S_IDLE: begin
          sel <= '0;
          if (enable) begin
            state <= S_SETTLE;
            cnt   <= '0;
            ones  <= '0;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          ones <= ones + ONES_W'(ising_s);
          if (cnt == SAMPLE_LAST) state <= S_STORE;
          else                    cnt   <= cnt + CNT_W'(1);
        end
        S_STORE: begin
          shadow <= shadow_nxt;
          cnt    <= '0;
          ones   <= '0;
          if (sel == LAST_CH) begin
            sensors   <= shadow_nxt;
            scan_done <= 1'b1;
            valid     <= 1'b1;
            sel       <= '0;
            state     <= enable ? S_SETTLE : S_IDLE;
          end else begin
            sel   <= sel + SEL_W'(1);
            state <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_infrarojo_scan.sv
// Scoreboard bench for infrarojo_scan: stimulus queues expected snapshots and
// completion cycles, a monitor pops them on every scan_done.

module tb_infrarojo_scan;
  localparam int N_CH    = 4;
  localparam int SETTLE  = 8;
  localparam int SAMPLES = 4;
  localparam int SEL_W   = 2;
  localparam int T       = 13;
  localparam int SCAN    = 52;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             ising = 1'b0;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0]  sensors;
  logic             valid, scan_done, busy;

  infrarojo_scan #(.N_CH(N_CH), .SETTLE(SETTLE), .SAMPLES(SAMPLES), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ising     (ising),
    .sel       (sel),
    .sensors   (sensors),
    .valid     (valid),
    .scan_done (scan_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Mux model; optionally overrides channel 2 with a per-sample sequence.
  // Samples land on the edges SETTLE-1 .. SETTLE+SAMPLES-2 after sel changes.
  logic [N_CH-1:0]  pattern = '0;
  logic             seq_en = 1'b0;
  logic [3:0]       seq = '0;
  logic [SEL_W-1:0] last_sel = '0;
  int               n = 0;

  always @(negedge clk) begin
    if (sel !== last_sel) n = 0;
    else                  n = n + 1;
    last_sel = sel;
    if (seq_en && sel == 2 && (n + 1) >= SETTLE - 1 && (n + 1) < SETTLE - 1 + SAMPLES)
      ising = seq[n + 2 - SETTLE];
    else
      ising = pattern[sel];
  end

  typedef struct {
    logic [N_CH-1:0] sens;
    int              at;
  } exp_t;

  exp_t q[$];
  exp_t e_pop;

  always @(negedge clk) begin
    if (scan_done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_scan_done at cycle %0d: got sensors=%b expected no pulse", cyc, sensors);
      end else begin
        e_pop = q.pop_front();
        chk("snapshot", 32'(sensors), 32'(e_pop.sens));
        chk("done_cycle", cyc, e_pop.at);
        chk("valid_at_done", 32'(valid), 32'd1);
      end
    end
  end

  // Snapshot may only move together with scan_done (reset excepted).
  logic [N_CH-1:0] prev_sens = '0;
  always @(negedge clk) begin
    if (rst_n && sensors !== prev_sens) begin
      checks++;
      if (!scan_done) begin
        failures++;
        $display("FAIL torn_snapshot at cycle %0d: got %b expected %b", cyc, sensors, prev_sens);
      end
    end
    prev_sens = sensors;
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_busy(output int e);
    int t;
    t = 0;
    while (!busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout at cycle %0d: got busy=0 expected 1", cyc);
    end
    e = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;

    // Reset held with enable high
    rst_n  = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_sensors", 32'(sensors), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_scan_done", 32'(scan_done), 0);
    chk("rst_busy", 32'(busy), 0);
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // Static pattern, single scan
    pattern = 4'b1101;
    enable  = 1'b1;
    wait_busy(e);
    enable = 1'b0;
    q.push_back('{sens: 4'b1101, at: e + SCAN});
    for (int k = 0; k < N_CH; k++) begin
      wait_until(e + k * T);
      chk("sel_step_start", 32'(sel), k);
      wait_until(e + k * T + T - 1);
      chk("sel_step_end", 32'(sel), k);
    end
    wait_until(e + SCAN + 2);
    chk("static_busy_after", 32'(busy), 0);
    chk("static_sel_after", 32'(sel), 0);
    chk("static_valid_after", 32'(valid), 1);

    // Majority filter on channel 2: 1,0,1,1 -> 1 then 1,1,0,0 -> 0
    pattern = 4'b1011;
    seq_en  = 1'b1;
    seq     = 4'b1101;
    enable  = 1'b1;
    wait_busy(e);
    enable = 1'b0;
    q.push_back('{sens: 4'b1111, at: e + SCAN});
    wait_until(e + SCAN + 2);
    seq    = 4'b0011;
    enable = 1'b1;
    wait_busy(e);
    enable = 1'b0;
    q.push_back('{sens: 4'b1011, at: e + SCAN});
    wait_until(e + SCAN + 2);
    seq_en = 1'b0;

    // Enable dropped mid-scan
    pattern = 4'b0110;
    enable  = 1'b1;
    wait_busy(e);
    q.push_back('{sens: 4'b0110, at: e + SCAN});
    wait_until(e + 20);
    enable = 1'b0;
    wait_until(e + SCAN + 1);
    chk("drop_busy_after", 32'(busy), 0);
    chk("drop_sel_after", 32'(sel), 0);
    repeat (60) @(negedge clk);
    chk("drop_stays_idle", 32'(busy), 0);

    // Reset mid-scan
    pattern = 4'b1111;
    enable  = 1'b1;
    wait_busy(e);
    wait_until(e + 29);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_sensors", 32'(sensors), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_sel", 32'(sel), 0);
    chk("midrst_scan_done", 32'(scan_done), 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midrst_valid_later", 32'(valid), 0);

    // Continuous scanning with a pattern change during scan 2, channel 3 settle
    pattern = 4'b1001;
    enable  = 1'b1;
    wait_busy(e);
    q.push_back('{sens: 4'b1001, at: e + SCAN});
    q.push_back('{sens: 4'b0001, at: e + 2 * SCAN});
    q.push_back('{sens: 4'b0010, at: e + 3 * SCAN});
    wait_until(e + SCAN + 3 * T + 3);
    chk("cont_sel_ch3", 32'(sel), 3);
    pattern = 4'b0010;
    wait_until(e + 2 * SCAN + 10);
    enable = 1'b0;
    wait_until(e + 3 * SCAN + 2);
    chk("cont_busy_after", 32'(busy), 0);
    chk("cont_sensors_final", 32'(sensors), 32'b0010);
    repeat (5) @(negedge clk);

    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
